// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: sequencer state encoding and
// signed saturation limits used by the multiplier and the divider.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } arith_state_t;

    // Bit patterns of the W-bit signed extremes, returned in 32 bits for slicing.
    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sign_mag_conv.sv
// Combinational two's-complement <-> sign/magnitude conversion: conditional negate.
module sign_mag_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/sdiv8by4_seq.sv
// Sequential signed 2W/W truncating divider with start/done handshake.
// Build option SDIV_OVF_SAT_EN: saturate the quotient on overflow instead of zeroing it.
//
//  state  | meaning
//  S_IDLE | waiting for start (ignored while the done pulse is high)
//  S_CALC | one restoring division step per cycle, WIDTH cycles
//  S_FIX  | apply signs, range check, register results and pulse done
module sdiv8by4_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf,
    output logic               dz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [31:0] SAT_MAX_32 = sat_max(WIDTH);
    localparam logic [31:0] SAT_MIN_32 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_32[WIDTH-1:0];

    arith_state_t state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               sign_q_q, sign_r_q, dz_q, ovf_hi_q;

    logic               busy_q, done_q, ovf_out_q, dz_out_q;
    logic [WIDTH-1:0]   quotient_q, remainder_q;

    logic               accept;
    logic [2*WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   q_signed, r_signed, q_mag;
    logic               range_fail, ovf_fix;
    logic [WIDTH-1:0]   q_result, r_result;

    assign accept = (state_q == S_IDLE) && start && !done_q;

    sign_mag_conv #(.WIDTH(2*WIDTH)) u_abs_dividend (
        .value  (dividend),
        .negate (dividend[2*WIDTH-1]),
        .result (dividend_mag)
    );

    sign_mag_conv #(.WIDTH(WIDTH)) u_abs_divisor (
        .value  (divisor),
        .negate (divisor[WIDTH-1]),
        .result (divisor_mag)
    );

    sign_mag_conv #(.WIDTH(WIDTH)) u_neg_quotient (
        .value  (acc_q[WIDTH-1:0]),
        .negate (sign_q_q),
        .result (q_signed)
    );

    sign_mag_conv #(.WIDTH(WIDTH)) u_neg_remainder (
        .value  (acc_q[2*WIDTH-1:WIDTH]),
        .negate (sign_r_q),
        .result (r_signed)
    );

    // Partial remainder after the shift is W+1 bits; an extra bit holds the borrow.
    assign diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, dvs_q};

    always_comb begin
        step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            step_acc = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    assign q_mag      = acc_q[WIDTH-1:0];
    assign range_fail = sign_q_q ? (q_mag > SAT_MIN) : (q_mag > SAT_MAX);
    assign ovf_fix    = dz_q | ovf_hi_q | range_fail;

    always_comb begin
        q_result = q_signed;
        r_result = r_signed;
        if (ovf_fix) begin
            r_result = '0;
`ifdef SDIV_OVF_SAT_EN
            // Divide-by-zero has no meaningful quotient sign, so follow the dividend.
            if (dz_q ? sign_r_q : sign_q_q) begin
                q_result = SAT_MIN;
            end else begin
                q_result = SAT_MAX;
            end
`else
            q_result = '0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_hi_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                cnt_q <= CNT_LOAD;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (accept) begin
                acc_q    <= dividend_mag;
                dvs_q    <= divisor_mag;
                sign_q_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                sign_r_q <= dividend[2*WIDTH-1];
                dz_q     <= (divisor == '0);
                ovf_hi_q <= (dividend_mag[2*WIDTH-1:WIDTH] >= divisor_mag);
            end else if (state_q == S_CALC) begin
                acc_q <= step_acc;
            end
        end
    end

    // busy stays up through the done cycle so a start there is visibly refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_out_q   <= 1'b0;
            dz_out_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIX);
            if (accept) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            if (state_q == S_FIX) begin
                quotient_q  <= q_result;
                remainder_q <= r_result;
                ovf_out_q   <= ovf_fix;
                dz_out_q    <= dz_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_out_q;
    assign dz        = dz_out_q;

endmodule

// File: tb/tb_sdiv8by4_seq.sv
// Directed-vector bench for sdiv8by4_seq (WIDTH=4); honours SDIV_OVF_SAT_EN.
module tb_sdiv8by4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       dz;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SDIV_OVF_SAT_EN
    localparam logic [3:0] Q_OVF_POS = 4'b0111;
    localparam logic [3:0] Q_OVF_NEG = 4'b1000;
`else
    localparam logic [3:0] Q_OVF_POS = 4'b0000;
    localparam logic [3:0] Q_OVF_NEG = 4'b0000;
`endif

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dz;
    } vec_t;

    vec_t vecs[14];

    sdiv8by4_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one division and return the number of edges after the start edge until done.
    task automatic do_div(input logic [7:0] a, input logic [3:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            chk("busy_in_window", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        int lat;
        int dones;

        vecs[0]  = '{8'hF9, 4'b0001, 4'b1001, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{8'hDB, 4'b0110, 4'b1010, 4'b1111, 1'b0, 1'b0};
        vecs[2]  = '{8'hD8, 4'b1000, 4'b0101, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{8'h08, 4'b0001, Q_OVF_POS, 4'b0000, 1'b1, 1'b0};
        vecs[4]  = '{8'hF8, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{8'hFB, 4'b0000, Q_OVF_NEG, 4'b0000, 1'b1, 1'b1};
        vecs[6]  = '{8'h07, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 4'b1000, Q_OVF_POS, 4'b0000, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{8'h17, 4'b1100, 4'b1011, 4'b0011, 1'b0, 1'b0};
        vecs[10] = '{8'hF7, 4'b0010, 4'b1100, 4'b1111, 1'b0, 1'b0};
        vecs[11] = '{8'h38, 4'b0111, Q_OVF_POS, 4'b0000, 1'b1, 1'b0};
        vecs[12] = '{8'hC8, 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{8'h05, 4'b0000, Q_OVF_POS, 4'b0000, 1'b1, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_outputs", {22'd0, quotient, remainder, ovf, dz}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 14; k++) begin
            do_div(vecs[k].dvd, vecs[k].dvs, lat);
            chk($sformatf("latency[%0d]", k), lat, 5);
            chk($sformatf("quotient[%0d]", k), {28'd0, quotient}, {28'd0, vecs[k].q});
            chk($sformatf("remainder[%0d]", k), {28'd0, remainder}, {28'd0, vecs[k].r});
            chk($sformatf("ovf[%0d]", k), {31'd0, ovf}, {31'd0, vecs[k].ovf});
            chk($sformatf("dz[%0d]", k), {31'd0, dz}, {31'd0, vecs[k].dz});
            @(posedge clk); #1;
            chk($sformatf("done_pulse[%0d]", k), {31'd0, done}, 32'd0);
            chk($sformatf("busy_drop[%0d]", k), {31'd0, busy}, 32'd0);
        end

        // start pulsed while busy must be ignored: one done, first operands' result
        dividend = 8'hF9;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dividend = 8'h08;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                chk("busy_start_q", {28'd0, quotient}, 32'h9);
                chk("busy_start_ovf", {31'd0, ovf}, 32'd0);
            end
        end
        chk("busy_start_dones", dones, 1);

        // results hold across a new start until the next done
        dividend = 8'h07;
        divisor  = 4'b0010;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold_quotient", {28'd0, quotient}, 32'h9);
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("hold_latency", lat, 5);
        chk("hold_new_q", {28'd0, quotient}, 32'h3);

        // start presented in the done cycle is refused
        dividend = 8'hDB;
        divisor  = 4'b0110;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_busy", {31'd0, busy}, 32'd0);
        expect_no_done("done_cycle_start_ignored", 10);
        chk("done_cycle_q_kept", {28'd0, quotient}, 32'h3);

        // reset in CALC cycle 2 aborts silently
        do_div(8'hF9, 4'b0001, lat);
        @(posedge clk); #1;
        dividend = 8'hDB;
        divisor  = 4'b0110;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_outputs", {22'd0, quotient, remainder, ovf, dz}, 32'd0);
        #2;
        rst_n = 1'b1;
        expect_no_done("abort_no_done", 10);

        do_div(8'hDB, 4'b0110, lat);
        chk("after_abort_latency", lat, 5);
        chk("after_abort_q", {28'd0, quotient}, 32'hA);
        chk("after_abort_r", {28'd0, remainder}, 32'hF);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
